// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma keypress sequencer.
//  - letter_t   : 5-bit letter / rotor position, A=1..Z=26, 0 = invalid
//  - stage_e    : shared datapath stage select, in traversal order
//  - state_e    : sequencer FSM states
//  - wrap_inc   : position increment with 26 -> 1 wrap
//  - letter_ok  : range check for 1..26
package enigma_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LETTER_INVALID = '0;

  // Default turnover positions for the fast (R1) and middle (R2) rotors.
  localparam letter_t NOTCH1_DEFAULT = 5'd17;
  localparam letter_t NOTCH2_DEFAULT = 5'd5;

  typedef enum logic [2:0] {
    S_R1     = 3'd0,
    S_R2     = 3'd1,
    S_R3     = 3'd2,
    S_REFL   = 3'd3,
    S_R3_INV = 3'd4,
    S_R2_INV = 3'd5,
    S_R1_INV = 3'd6
  } stage_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StPass = 2'd2,
    StDone = 2'd3
  } state_e;

  // Compare against 26 before incrementing so 5 bits never overflow.
  function automatic letter_t wrap_inc(input letter_t v);
    return (v >= letter_t'(NUM_LETTERS)) ? letter_t'(1) : letter_t'(v + 1'b1);
  endfunction

  function automatic logic letter_ok(input letter_t v);
    return (v != LETTER_INVALID) && (v <= letter_t'(NUM_LETTERS));
  endfunction

endpackage

// File: rtl/enigma_if.sv
// Bus bundle between the sequencer and its surroundings (keyboard decode, rotor
// datapath, display).
//  slave  : the sequencer's view (takes keypress/load/stage_out/out_ready, drives the rest)
//  master : the environment's view (keyboard, datapath and display together)
// Keypress : in_valid, in_letter, in_ready
// Load     : load_pos, pos_init1..3
// Status   : pos1..pos3, error
// Datapath : stage_sel, stage_in, stage_rotate, stage_out
// Result   : out_valid, out_letter, out_ready
interface enigma_if;
  import enigma_pkg::*;

  logic        in_valid;
  letter_t     in_letter;
  logic        in_ready;
  logic        load_pos;
  letter_t     pos_init1;
  letter_t     pos_init2;
  letter_t     pos_init3;
  letter_t     pos1;
  letter_t     pos2;
  letter_t     pos3;
  logic [2:0]  stage_sel;
  letter_t     stage_in;
  letter_t     stage_rotate;
  letter_t     stage_out;
  logic        out_valid;
  letter_t     out_letter;
  logic        out_ready;
  logic        error;

  modport slave (
    input  in_valid, in_letter, load_pos, pos_init1, pos_init2, pos_init3, stage_out,
           out_ready,
    output in_ready, pos1, pos2, pos3, stage_sel, stage_in, stage_rotate, out_valid,
           out_letter, error
  );

  modport master (
    output in_valid, in_letter, load_pos, pos_init1, pos_init2, pos_init3, stage_out,
           out_ready,
    input  in_ready, pos1, pos2, pos3, stage_sel, stage_in, stage_rotate, out_valid,
           out_letter, error
  );

endinterface

// File: rtl/rotor_stepper.sv
// Combinational next-position logic for the three rotors (odometer with the
// middle-rotor double step).
//  pos1..pos3     : current (pre-step) positions, 1..26
//  notch1, notch2 : turnover positions of R1 and R2
//  next1..next3   : positions after one keypress step
module rotor_stepper
  import enigma_pkg::*;
(
  input  letter_t pos1,
  input  letter_t pos2,
  input  letter_t pos3,
  input  letter_t notch1,
  input  letter_t notch2,
  output letter_t next1,
  output letter_t next2,
  output letter_t next3
);

  logic fast_at_notch;
  logic mid_at_notch;

  assign fast_at_notch = (pos1 == notch1);
  assign mid_at_notch  = (pos2 == notch2);

  assign next1 = wrap_inc(pos1);
  // R2 at its own notch steps again together with R3: the double step.
  assign next2 = (fast_at_notch || mid_at_notch) ? wrap_inc(pos2) : pos2;
  assign next3 = mid_at_notch ? wrap_inc(pos3) : pos3;

endmodule

// File: rtl/enigma_sequencer.sv
// Keypress controller for the Enigma datapath. Per accepted letter it steps the
// rotors once, then walks one shared rotor-lookup datapath through seven stages
// (R1, R2, R3, reflector, R3_inv, R2_inv, R1_inv) and presents the result.
//  clk, rst : clock, synchronous active-high reset
//  bus      : enigma_if slave view (keypress, load, status, datapath, result)
// Parameters NOTCH1/NOTCH2 are the R1/R2 turnover positions.
module enigma_sequencer
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH1 = NOTCH1_DEFAULT,
  parameter letter_t NOTCH2 = NOTCH2_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  enigma_if.slave  bus
);

  state_e  state_q;
  letter_t pos1_q, pos2_q, pos3_q;
  letter_t next1, next2, next3;
  letter_t data_q;
  stage_e  stage_sel_q;
  letter_t stage_in_q;
  letter_t stage_rotate_q;
  logic    out_valid_q;
  letter_t out_letter_q;
  logic    error_q;
  stage_e  stage_nxt;

  rotor_stepper u_stepper (
    .pos1   (pos1_q),
    .pos2   (pos2_q),
    .pos3   (pos3_q),
    .notch1 (NOTCH1),
    .notch2 (NOTCH2),
    .next1  (next1),
    .next2  (next2),
    .next3  (next3)
  );

  // Rotation applied by each stage: the owning rotor's position, none for the reflector.
  function automatic letter_t rotate_for(input stage_e k, input letter_t p1, input letter_t p2,
                                         input letter_t p3);
    unique case (k)
      S_R1, S_R1_INV: return p1;
      S_R2, S_R2_INV: return p2;
      S_R3, S_R3_INV: return p3;
      default:        return '0;
    endcase
  endfunction

  assign stage_nxt = stage_e'(stage_sel_q + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      pos1_q         <= letter_t'(1);
      pos2_q         <= letter_t'(1);
      pos3_q         <= letter_t'(1);
      data_q         <= '0;
      stage_sel_q    <= S_R1;
      stage_in_q     <= '0;
      stage_rotate_q <= '0;
      out_valid_q    <= 1'b0;
      out_letter_q   <= '0;
      error_q        <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A load in the same cycle as a keypress takes priority; the keypress is dropped.
          if (bus.load_pos) begin
            pos1_q <= bus.pos_init1;
            pos2_q <= bus.pos_init2;
            pos3_q <= bus.pos_init3;
          end else if (bus.in_valid) begin
            if (letter_ok(bus.in_letter)) begin
              data_q  <= bus.in_letter;
              state_q <= StStep;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StStep: begin
          pos1_q         <= next1;
          pos2_q         <= next2;
          pos3_q         <= next3;
          // First stage needs the post-step R1 position, which lands this same edge.
          stage_sel_q    <= S_R1;
          stage_in_q     <= data_q;
          stage_rotate_q <= next1;
          state_q        <= StPass;
        end
        StPass: begin
          if (bus.stage_out == LETTER_INVALID) begin
            error_q        <= 1'b1;
            stage_sel_q    <= S_R1;
            stage_in_q     <= '0;
            stage_rotate_q <= '0;
            state_q        <= StIdle;
          end else begin
            data_q <= bus.stage_out;
            if (stage_sel_q == S_R1_INV) begin
              stage_sel_q    <= S_R1;
              stage_in_q     <= '0;
              stage_rotate_q <= '0;
              state_q        <= StDone;
            end else begin
              stage_sel_q    <= stage_nxt;
              stage_in_q     <= bus.stage_out;
              stage_rotate_q <= rotate_for(stage_nxt, pos1_q, pos2_q, pos3_q);
            end
          end
        end
        StDone: begin
          // First DONE cycle registers the result; it is then held until taken.
          if (!out_valid_q) begin
            out_valid_q  <= 1'b1;
            out_letter_q <= data_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.pos1         = pos1_q;
  assign bus.pos2         = pos2_q;
  assign bus.pos3         = pos3_q;
  assign bus.stage_sel    = stage_sel_q;
  assign bus.stage_in     = stage_in_q;
  assign bus.stage_rotate = stage_rotate_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_letter   = out_letter_q;
  assign bus.error        = error_q;

endmodule
